div_seq: RTL and testbench

//  Parametrised multi-cycle integer divider, successor of the single-mode radix-2 divider.

---
 rtl/div_seq_if.sv | 27 ++
 rtl/div_seq.sv | 171 +++++++++++++++++
 tb/tb_div_seq.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Handshake/data bundle of the sequential divider.
// The master drives the start request and operands; the slave returns the results and status.
interface div_seq_if #(
    parameter int DATA_W = 32
);
    logic              I_EN;
    logic              I_SGN;
    logic [DATA_W-1:0] I_NUM;
    logic [DATA_W-1:0] I_DEN;
    logic [DATA_W-1:0] O_RSL;
    logic [DATA_W-1:0] O_REM;
    logic              O_BUSY;
    logic              O_VLD;
    logic              O_FN;
    logic              O_DZ;
    logic              O_OVF;

    modport master (
        output I_EN, I_SGN, I_NUM, I_DEN,
        input  O_RSL, O_REM, O_BUSY, O_VLD, O_FN, O_DZ, O_OVF
    );

    modport slave (
        input  I_EN, I_SGN, I_NUM, I_DEN,
        output O_RSL, O_REM, O_BUSY, O_VLD, O_FN, O_DZ, O_OVF
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring integer divider, signed or unsigned per operation.
// Resolves BPC quotient bits per clock on operand magnitudes, then fixes signs in one final cycle.
// Divide-by-zero skips the iteration entirely; MIN / -1 wraps naturally and raises O_OVF.
module div_seq #(
    parameter int DATA_W = 32,
    parameter int BPC    = 1
) (
    input logic      CLK,
    input logic      RST,
    div_seq_if.slave bus
);
    localparam int N  = DATA_W / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(N - 1);
    localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

    if (DATA_W < 4 || (DATA_W % BPC) != 0 || !(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_param
        $error("div_seq: DATA_W must be >= 4 and a multiple of BPC, BPC must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Magnitude of an operand; |MIN| comes out as the unsigned value 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic as_signed);
        logic signed [DATA_W-1:0] s;
        s = v;
        if (as_signed && s < 0) begin
            return ~v + DATA_W'(1);
        end
        return v;
    endfunction

    // Two's-complement negation applied only when the sign fix-up calls for it.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              neg_q;      // quotient must be negated
    logic              neg_r;      // remainder must be negated
    logic              dz_q;
    logic              ovf_q;

    // Datapath: numerator magnitude shifts out MSB-first while quotient bits shift in at the LSB.
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] den_q;
    logic [DATA_W-1:0] num_q;      // raw numerator, returned as remainder on divide-by-zero

    logic [DATA_W-1:0] quo_c;
    logic [DATA_W-1:0] acc_c;
    logic [DATA_W:0]   sh;
    logic [DATA_W:0]   diff;

    logic [DATA_W-1:0] rsl_r;
    logic [DATA_W-1:0] rem_r;
    logic              busy_r;
    logic              vld_r;
    logic              fn_r;
    logic              dz_r;
    logic              ovf_r;

    logic              start;
    logic              den_zero;
    logic              is_ovf;

    assign start    = (state == IDLE) && bus.I_EN;
    assign den_zero = (bus.I_DEN == '0);
    assign is_ovf   = bus.I_SGN && (bus.I_NUM == MIN_VAL) && (bus.I_DEN == '1);

    // BPC restoring steps chained within one clock; the DATA_W+1 bit difference MSB is the borrow.
    always_comb begin
        acc_c = acc_q;
        quo_c = quo_q;
        sh    = '0;
        diff  = '0;
        for (int i = 0; i < BPC; i++) begin
            sh    = {acc_c, quo_c[DATA_W-1]};
            diff  = sh - {1'b0, den_q};
            quo_c = {quo_c[DATA_W-2:0], ~diff[DATA_W]};
            acc_c = diff[DATA_W] ? sh[DATA_W-1:0] : diff[DATA_W-1:0];
        end
    end

    // Operand latch at an accepted start, iteration update while calculating.
    always_ff @(posedge CLK) begin
        if (start) begin
            quo_q <= mag(bus.I_NUM, bus.I_SGN);
            den_q <= mag(bus.I_DEN, bus.I_SGN);
            num_q <= bus.I_NUM;
            acc_q <= '0;
        end else if (state == CALC) begin
            quo_q <= quo_c;
            acc_q <= acc_c;
        end
    end

    // Control FSM with registered result/status outputs; reset aborts any operation at once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            rsl_r  <= '0;
            rem_r  <= '0;
            busy_r <= 1'b0;
            vld_r  <= 1'b0;
            fn_r   <= 1'b0;
            dz_r   <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            vld_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.I_EN) begin
                        neg_q  <= bus.I_SGN & (bus.I_NUM[DATA_W-1] ^ bus.I_DEN[DATA_W-1]);
                        neg_r  <= bus.I_SGN & bus.I_NUM[DATA_W-1];
                        dz_q   <= den_zero;
                        ovf_q  <= is_ovf;
                        fn_r   <= 1'b0;
                        dz_r   <= 1'b0;
                        ovf_r  <= 1'b0;
                        busy_r <= 1'b1;
                        cnt    <= CNT_LAST;
                        state  <= den_zero ? FIX : CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz_q) begin
                        rsl_r <= '1;
                        rem_r <= num_q;
                    end else begin
                        rsl_r <= cond_neg(quo_q, neg_q);
                        rem_r <= cond_neg(acc_q, neg_r);
                    end
                    dz_r   <= dz_q;
                    ovf_r  <= ovf_q;
                    vld_r  <= 1'b1;
                    fn_r   <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.O_RSL  = rsl_r;
    assign bus.O_REM  = rem_r;
    assign bus.O_BUSY = busy_r;
    assign bus.O_VLD  = vld_r;
    assign bus.O_FN   = fn_r;
    assign bus.O_DZ   = dz_r;
    assign bus.O_OVF  = ovf_r;
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: a BPC=1 and a BPC=4 instance, directed vector table, hand-written
// multi-cycle sequences (busy-ignore, back-to-back, reset abort) and randomized operations
// checked against a plain-arithmetic reference model.
module tb_div_seq;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    div_seq_if #(.DATA_W(W)) if1 ();
    div_seq_if #(.DATA_W(W)) if4 ();

    div_seq #(.DATA_W(W), .BPC(1)) u_dut1 (.CLK(CLK), .RST(RST), .bus(if1));
    div_seq #(.DATA_W(W), .BPC(4)) u_dut4 (.CLK(CLK), .RST(RST), .bus(if4));

    int tests = 0;
    int fails = 0;
    logic [W-1:0] prev_rsl [2];

    typedef struct {
        int         sel;
        logic       sgn;
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic       dz;
        logic       ovf;
        int         lat;
    } vec_t;

    vec_t vecs [14];

    function automatic int idx(input int sel);
        return (sel == 1) ? 0 : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic en, input logic sgn,
                         input logic [W-1:0] num, input logic [W-1:0] den);
        if (sel == 1) begin
            if1.I_EN = en; if1.I_SGN = sgn; if1.I_NUM = num; if1.I_DEN = den;
        end else begin
            if4.I_EN = en; if4.I_SGN = sgn; if4.I_NUM = num; if4.I_DEN = den;
        end
    endtask

    task automatic set_en(input int sel, input logic en);
        if (sel == 1) if1.I_EN = en;
        else          if4.I_EN = en;
    endtask

    task automatic sample(input int sel, output logic [W-1:0] rsl, output logic [W-1:0] rem,
                          output logic vld, output logic busy, output logic fn,
                          output logic dz, output logic ovf);
        if (sel == 1) begin
            rsl = if1.O_RSL; rem = if1.O_REM; vld = if1.O_VLD; busy = if1.O_BUSY;
            fn = if1.O_FN; dz = if1.O_DZ; ovf = if1.O_OVF;
        end else begin
            rsl = if4.O_RSL; rem = if4.O_REM; vld = if4.O_VLD; busy = if4.O_BUSY;
            fn = if4.O_FN; dz = if4.O_DZ; ovf = if4.O_OVF;
        end
    endtask

    // Reference: plain 64-bit integer division (truncating, remainder follows dividend).
    task automatic model(input logic sgn, input logic [W-1:0] num, input logic [W-1:0] den,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ovf);
        longint n, d;
        dz  = 1'b0;
        ovf = 1'b0;
        if (den == '0) begin
            q  = '1;
            r  = num;
            dz = 1'b1;
        end else begin
            if (sgn) begin
                n = $signed(num);
                d = $signed(den);
                ovf = (n == -64'sd2147483648) && (d == -64'sd1);
            end else begin
                n = {32'd0, num};
                d = {32'd0, den};
            end
            q = W'(n / d);
            r = W'(n % d);
        end
    endtask

    // Start one operation from an idle DUT (called at a negedge) and wait for O_VLD.
    task automatic run_op(input int sel, input logic sgn, input logic [W-1:0] num,
                          input logic [W-1:0] den, input int pulse_at,
                          output logic [W-1:0] rsl, output logic [W-1:0] rem,
                          output logic dz, output logic ovf, output logic fn, output int lat);
        logic [W-1:0] r_, m_;
        logic vld_, busy_, fn_, dz_, ovf_;
        drive(sel, 1'b1, sgn, num, den);
        lat = 0;
        r_ = '0; m_ = '0; fn_ = 1'b0; dz_ = 1'b0; ovf_ = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            sample(sel, r_, m_, vld_, busy_, fn_, dz_, ovf_);
            if (c == 1) begin
                set_en(sel, 1'b0);
                chk("busy_after_start", busy_, 1'b1);
                chk("fn_cleared_on_start", fn_, 1'b0);
                chk("rsl_held_while_busy", r_, prev_rsl[idx(sel)]);
            end
            if (pulse_at > 0 && c == pulse_at)     set_en(sel, 1'b1);
            if (pulse_at > 0 && c == pulse_at + 1) set_en(sel, 1'b0);
            if (vld_) begin
                lat = c;
                break;
            end
        end
        set_en(sel, 1'b0);
        if (lat == 0) begin
            tests++;
            fails++;
            $display("FAIL vld_timeout: no O_VLD within 100 cycles (sel %0d)", sel);
        end
        rsl = r_; rem = m_; dz = dz_; ovf = ovf_; fn = fn_;
        prev_rsl[idx(sel)] = r_;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rsl, rem, eq, er, num, den, r2, m2;
        logic dz, ovf, fn, edz, eovf, vld, busy;
        int lat, cnt, gap, sel, mode;
        logic sgn;

        prev_rsl[0] = '0;
        prev_rsl[1] = '0;
        drive(1, 1'b0, 1'b0, '0, '0);
        drive(4, 1'b0, 1'b0, '0, '0);

        vecs[0]  = '{1, 1'b1, 32'd100,       32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 34};
        vecs[1]  = '{1, 1'b1, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 34};
        vecs[2]  = '{1, 1'b1, 32'd100,       32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 34};
        vecs[3]  = '{1, 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 34};
        vecs[4]  = '{1, 1'b0, 32'hFFFFFFFF,  32'd2,        32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 34};
        vecs[5]  = '{1, 1'b1, 32'hFFFFFFFF,  32'd2,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 34};
        vecs[6]  = '{1, 1'b0, 32'd5,         32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 2};
        vecs[7]  = '{1, 1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 34};
        vecs[8]  = '{4, 1'b0, 32'd1000000,   32'd3,        32'd333333,   32'd1,        1'b0, 1'b0, 10};
        vecs[9]  = '{4, 1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 10};
        vecs[10] = '{4, 1'b1, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0, 2};
        vecs[11] = '{4, 1'b0, 32'h80000000,  32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0, 10};
        vecs[12] = '{1, 1'b1, 32'h80000000,  32'd2,        32'hC0000000, 32'd0,        1'b0, 1'b0, 34};
        vecs[13] = '{4, 1'b1, 32'd7,         32'hFFFFFFFF, 32'hFFFFFFF9, 32'd0,        1'b0, 1'b0, 10};

        // Reset state of both instances.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 0) ? 1 : 4;
            sample(sel, rsl, rem, vld, busy, fn, dz, ovf);
            chk("reset_rsl", rsl, '0);
            chk("reset_rem", rem, '0);
            chk("reset_busy", busy, 1'b0);
            chk("reset_vld", vld, 1'b0);
            chk("reset_fn", fn, 1'b0);
            chk("reset_dz", dz, 1'b0);
            chk("reset_ovf", ovf, 1'b0);
        end
        RST = 1'b0;
        @(negedge CLK);

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].sel, vecs[i].sgn, vecs[i].num, vecs[i].den, 0, rsl, rem, dz, ovf, fn, lat);
            chk($sformatf("vec%0d_rsl", i), rsl, vecs[i].q);
            chk($sformatf("vec%0d_rem", i), rem, vecs[i].r);
            chk($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
            chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
            chk($sformatf("vec%0d_fn", i), fn, 1'b1);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            @(negedge CLK);
            sample(vecs[i].sel, r2, m2, vld, busy, fn, dz, ovf);
            chk($sformatf("vec%0d_vld_pulse", i), vld, 1'b0);
            chk($sformatf("vec%0d_fn_held", i), fn, 1'b1);
            chk($sformatf("vec%0d_rsl_held", i), r2, vecs[i].q);
        end

        // I_EN pulsed while busy must be ignored, with nothing queued.
        run_op(4, 1'b0, 32'd1000000, 32'd3, 3, rsl, rem, dz, ovf, fn, lat);
        chk("ign_rsl", rsl, 32'd333333);
        chk("ign_rem", rem, 32'd1);
        chk("ign_latency", lat, 10);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            sample(4, r2, m2, vld, busy, fn, dz, ovf);
            if (vld || busy) cnt++;
        end
        chk("ign_no_queued_op", cnt, 0);

        // Back-to-back: I_EN held high restarts right after FIX, every N+2 clocks.
        drive(4, 1'b1, 1'b0, 32'd1000, 32'd10);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            sample(4, rsl, rem, vld, busy, fn, dz, ovf);
            if (vld) begin lat = c; break; end
        end
        chk("b2b_first_rsl", rsl, 32'd100);
        chk("b2b_first_latency", lat, 10);
        drive(4, 1'b1, 1'b0, 32'd77, 32'd7);
        gap = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            sample(4, rsl, rem, vld, busy, fn, dz, ovf);
            if (vld) begin gap = c; break; end
        end
        set_en(4, 1'b0);
        chk("b2b_second_rsl", rsl, 32'd11);
        chk("b2b_second_rem", rem, 32'd0);
        chk("b2b_gap", gap, 10);
        prev_rsl[1] = rsl;
        @(negedge CLK);

        // Reset in the middle of a calculation.
        drive(1, 1'b1, 1'b1, 32'd100, 32'd7);
        for (int c = 1; c <= 10; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (c == 1) set_en(1, 1'b0);
        end
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        sample(1, rsl, rem, vld, busy, fn, dz, ovf);
        chk("rst_mid_rsl", rsl, '0);
        chk("rst_mid_rem", rem, '0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_vld", vld, 1'b0);
        chk("rst_mid_fn", fn, 1'b0);
        chk("rst_mid_ovf", ovf, 1'b0);
        RST = 1'b0;
        prev_rsl[0] = '0;
        prev_rsl[1] = '0;
        @(negedge CLK);
        run_op(1, 1'b0, 32'd9, 32'd4, 0, rsl, rem, dz, ovf, fn, lat);
        chk("after_rst_rsl", rsl, 32'd2);
        chk("after_rst_rem", rem, 32'd1);
        chk("after_rst_latency", lat, 34);

        // Randomized operations on both instances against the reference model.
        for (int s = 0; s < 2; s++) begin
            sel = (s == 0) ? 1 : 4;
            for (int i = 0; i < 150; i++) begin
                sgn  = 1'($urandom_range(0, 1));
                num  = $urandom;
                mode = $urandom_range(0, 9);
                case (mode)
                    0: den = '0;
                    1: begin num = 32'h80000000; den = 32'hFFFFFFFF; end
                    2, 3, 4: begin
                        den = 32'($urandom_range(1, 20));
                        if ($urandom_range(0, 1) == 1) den = ~den + 32'd1;
                    end
                    5: num = 32'($urandom_range(0, 50));
                    default: den = $urandom;
                endcase
                model(sgn, num, den, eq, er, edz, eovf);
                run_op(sel, sgn, num, den, 0, rsl, rem, dz, ovf, fn, lat);
                chk($sformatf("rnd%0d_%0d_rsl", sel, i), rsl, eq);
                chk($sformatf("rnd%0d_%0d_rem", sel, i), rem, er);
                chk($sformatf("rnd%0d_%0d_dz", sel, i), dz, edz);
                chk($sformatf("rnd%0d_%0d_ovf", sel, i), ovf, eovf);
                chk($sformatf("rnd%0d_%0d_latency", sel, i), lat,
                    edz ? 2 : ((sel == 1) ? 34 : 10));
                @(negedge CLK);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
